// File: rtl/dbus_pkg.sv
// Shared types and helpers for the two-master Data_RAM arbiter/sequencer.
package dbus_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    typedef logic mst_t;
    localparam mst_t MST_M0 = 1'b0;
    localparam mst_t MST_M1 = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        logic [2:0] n;
        case (f3)
            F3_LB, F3_LBU: n = 3'd1;
            F3_LH, F3_LHU: n = 3'd2;
            default:       n = 3'd4;
        endcase
        return n;
    endfunction

    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
    function automatic logic in_window(input logic [31:0] addr, input logic [2:0] f3,
                                       input logic [32:0] limit);
        logic [32:0] last;
        last = {1'b0, addr} + {30'd0, access_bytes(f3)} - 33'd1;
        return (last < limit);
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the winner on advance.
module rr_arb2
    import dbus_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    mst_t       ptr_q;
    mst_t       ptr_d;
    logic [1:0] gnt;

    // Grant selection and pointer update.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == MST_M1) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (advance_i) begin
            ptr_d = gnt[0] ? MST_M1 : MST_M0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= MST_M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates core (M0) and debug (M1) masters onto the single Data_RAM port.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int RAM_BYTES  = 256,
    parameter int RD_LATENCY = 0
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iM0_Req,
    input  logic        iM0_WrEn,
    input  logic [31:0] iM0_Addr,
    input  logic [31:0] iM0_WrData,
    input  logic [2:0]  iM0_Funct3,
    output logic        oM0_Ack,
    output logic        oM0_Err,
    output logic [31:0] oM0_RdData,
    input  logic        iM1_Req,
    input  logic        iM1_WrEn,
    input  logic [31:0] iM1_Addr,
    input  logic [31:0] iM1_WrData,
    input  logic [2:0]  iM1_Funct3,
    output logic        oM1_Ack,
    output logic        oM1_Err,
    output logic [31:0] oM1_RdData,
    output logic        oS_WrEn,
    output logic [31:0] oS_Addr,
    output logic [31:0] oS_WrData,
    output logic [2:0]  oS_Funct3,
    input  logic [31:0] iS_RdData
);

    localparam int CNT_INIT = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    state_e      state_q, state_d;
    mst_t        owner_q, owner_d;
    logic        wr_q, wr_d, inr_q, inr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  gnt;
    logic        advance;
    logic        sel_wr;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_f3;

    logic        s_wren_q, s_wren_d;
    logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic [2:0]  s_f3_q, s_f3_d;
    logic [1:0]  ack_q, ack_d, err_q, err_d;
    logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;

    rr_arb2 u_arb (
        .clk_i     (iClk),
        .rst_ni    (iRst),
        .req_i     ({iM1_Req, iM0_Req}),
        .advance_i (advance),
        .gnt_o     (gnt)
    );

    assign sel_wr    = gnt[1] ? iM1_WrEn   : iM0_WrEn;
    assign sel_addr  = gnt[1] ? iM1_Addr   : iM0_Addr;
    assign sel_wdata = gnt[1] ? iM1_WrData : iM0_WrData;
    assign sel_f3    = gnt[1] ? iM1_Funct3 : iM0_Funct3;

    // Sequencer next-state and transaction latches.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        inr_d   = inr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    advance = 1'b1;
                    owner_d = gnt[1] ? MST_M1 : MST_M0;
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    f3_d    = sel_f3;
                    inr_d   = in_window(sel_addr, sel_f3, 33'(RAM_BYTES));
                    rdata_d = 32'h0000_0000;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if ((RD_LATENCY == 0) || wr_q || !inr_q) begin
                    if (!wr_q && inr_q) begin
                        rdata_d = iS_RdData;
                    end else begin
                        rdata_d = 32'h0000_0000;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 2'(CNT_INIT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = iS_RdData;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming state, so every port is driven from a flop.
    always_comb begin
        s_wren_d  = (state_d == S_ACCESS) && wr_d && inr_d;
        s_addr_d  = 32'h0000_0000;
        s_wdata_d = 32'h0000_0000;
        s_f3_d    = 3'b000;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        rd0_d     = 32'h0000_0000;
        rd1_d     = 32'h0000_0000;
        if ((state_d == S_ACCESS) || (state_d == S_WAIT)) begin
            s_addr_d  = addr_d;
            s_wdata_d = wdata_d;
            s_f3_d    = f3_d;
        end else if (state_d == S_RESP) begin
            ack_d[owner_d] = 1'b1;
            err_d[owner_d] = !inr_d;
            if (inr_d && !wr_d) begin
                if (owner_d == MST_M1) begin
                    rd1_d = rdata_d;
                end else begin
                    rd0_d = rdata_d;
                end
            end else begin
                rd0_d = 32'h0000_0000;
            end
        end else begin
            s_addr_d = 32'h0000_0000;
        end
    end

    // State, latches and output registers; reset aborts any transaction in flight.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= S_IDLE;
            owner_q   <= MST_M0;
            wr_q      <= 1'b0;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            f3_q      <= 3'b000;
            inr_q     <= 1'b0;
            cnt_q     <= 2'd0;
            rdata_q   <= 32'h0000_0000;
            s_wren_q  <= 1'b0;
            s_addr_q  <= 32'h0000_0000;
            s_wdata_q <= 32'h0000_0000;
            s_f3_q    <= 3'b000;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            rd0_q     <= 32'h0000_0000;
            rd1_q     <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            inr_q     <= inr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            s_wren_q  <= s_wren_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_f3_q    <= s_f3_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    assign oS_WrEn    = s_wren_q;
    assign oS_Addr    = s_addr_q;
    assign oS_WrData  = s_wdata_q;
    assign oS_Funct3  = s_f3_q;
    assign oM0_Ack    = ack_q[0];
    assign oM1_Ack    = ack_q[1];
    assign oM0_Err    = err_q[0];
    assign oM1_Err    = err_q[1];
    assign oM0_RdData = rd0_q;
    assign oM1_RdData = rd1_q;

endmodule
